mac_psum_accumulator: RTL and testbench

- Downstream of the faulty MAC slice. Consumes one 16-bit slice sum per accepted beat and accumulates N_SLICES beats into one wide output-neuron result.
- Each beat carries the fault-injected sum alongside the fault-free golden sum. The block counts per-result mismatches so the fault campaign can score each injected fault.
- Output is delivered over a valid/ready handshake with backpressure.

---
 rtl/mac_psum_accumulator_if.sv | 33 +++
 rtl/mac_psum_accumulator.sv | 178 +++++++++++++++++
 tb/tb_mac_psum_accumulator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mac_psum_accumulator_if.sv
// Beat-in / result-out bundle for the partial-sum accumulator.
// The slave side is the accumulator; the master side is the producer/consumer pair.
interface mac_psum_accumulator_if #(
    parameter int SUM_W    = 16,
    parameter int ACC_W    = 24,
    parameter int N_SLICES = 4,
    parameter int ERR_W    = $clog2(N_SLICES + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] sum_in;
    logic [SUM_W-1:0] golden_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [ACC_W-1:0] out_golden;
    logic [ERR_W-1:0] out_err_cnt;
    logic             out_mismatch;
    logic             out_sat;
    logic [15:0]      result_cnt;

    modport slave (
        input  in_valid, sum_in, golden_in, out_ready,
        output in_ready, out_valid, out_data, out_golden, out_err_cnt,
               out_mismatch, out_sat, result_cnt
    );

    modport master (
        output in_valid, sum_in, golden_in, out_ready,
        input  in_ready, out_valid, out_data, out_golden, out_err_cnt,
               out_mismatch, out_sat, result_cnt
    );
endinterface

// File: rtl/mac_psum_accumulator.sv
// Accumulates N_SLICES faulty/golden slice sums into one saturating result
// and counts the beats where the injected fault changed the slice sum.
module mac_psum_accumulator #(
    parameter int SUM_W    = 16,
    parameter int ACC_W    = 24,
    parameter int N_SLICES = 4,
    parameter int ERR_W    = $clog2(N_SLICES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    mac_psum_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] gacc_q, gacc_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             sat_q, sat_d;
    logic             out_valid_q, out_valid_d;
    logic             mismatch_q, mismatch_d;
    logic [15:0]      result_cnt_q, result_cnt_d;

    logic             beat_s;
    logic [ACC_W-1:0] acc_base_s, gacc_base_s;
    logic [ERR_W-1:0] err_base_s, cnt_base_s;
    logic             sat_base_s;
    logic [ACC_W:0]   acc_sum_s, gacc_sum_s;
    logic [ACC_W-1:0] acc_new_s, gacc_new_s;
    logic [ERR_W-1:0] cnt_new_s;

    // Returns {overflow, value}; an overflowing sum clamps to all-ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(b);
        if (s[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = s;
        end
    endfunction

    assign beat_s = bus.in_valid && (state_q != HOLD);

    // In IDLE the first beat loads, which is the same as adding onto zero.
    always_comb begin
        if (state_q == IDLE) begin
            acc_base_s  = '0;
            gacc_base_s = '0;
            err_base_s  = '0;
            cnt_base_s  = '0;
            sat_base_s  = 1'b0;
        end else begin
            acc_base_s  = acc_q;
            gacc_base_s = gacc_q;
            err_base_s  = err_q;
            cnt_base_s  = cnt_q;
            sat_base_s  = sat_q;
        end
        acc_sum_s  = sat_add(acc_base_s, bus.sum_in);
        gacc_sum_s = sat_add(gacc_base_s, bus.golden_in);
        acc_new_s  = acc_sum_s[ACC_W-1:0];
        gacc_new_s = gacc_sum_s[ACC_W-1:0];
        cnt_new_s  = cnt_base_s + ERR_W'(1);
    end

    // Next-state and datapath update; clear overrides beats and handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        gacc_d       = gacc_q;
        err_d        = err_q;
        sat_d        = sat_q;
        out_valid_d  = out_valid_q;
        mismatch_d   = mismatch_q;
        result_cnt_d = result_cnt_q;
        if (clear) begin
            state_d     = IDLE;
            cnt_d       = '0;
            acc_d       = '0;
            gacc_d      = '0;
            err_d       = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
            mismatch_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_s) begin
                        acc_d  = acc_new_s;
                        gacc_d = gacc_new_s;
                        err_d  = err_base_s + ERR_W'(bus.sum_in != bus.golden_in);
                        sat_d  = sat_base_s | acc_sum_s[ACC_W] | gacc_sum_s[ACC_W];
                        cnt_d  = cnt_new_s;
                        if (cnt_new_s == ERR_W'(N_SLICES)) begin
                            state_d     = HOLD;
                            out_valid_d = 1'b1;
                            mismatch_d  = (acc_new_s != gacc_new_s);
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d      = IDLE;
                        cnt_d        = '0;
                        acc_d        = '0;
                        gacc_d       = '0;
                        err_d        = '0;
                        sat_d        = 1'b0;
                        out_valid_d  = 1'b0;
                        mismatch_d   = 1'b0;
                        result_cnt_d = result_cnt_q + 16'd1;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    acc_d       = '0;
                    gacc_d      = '0;
                    err_d       = '0;
                    sat_d       = 1'b0;
                    out_valid_d = 1'b0;
                    mismatch_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            gacc_q       <= '0;
            err_q        <= '0;
            sat_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            mismatch_q   <= 1'b0;
            result_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            gacc_q       <= gacc_d;
            err_q        <= err_d;
            sat_q        <= sat_d;
            out_valid_q  <= out_valid_d;
            mismatch_q   <= mismatch_d;
            result_cnt_q <= result_cnt_d;
        end
    end

    assign bus.in_ready     = (state_q != HOLD);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = acc_q;
    assign bus.out_golden   = gacc_q;
    assign bus.out_err_cnt  = err_q;
    assign bus.out_mismatch = mismatch_q;
    assign bus.out_sat      = sat_q;
    assign bus.result_cnt   = result_cnt_q;

endmodule

// File: tb/tb_mac_psum_accumulator.sv
// Directed bench: one default instance and one with ACC_W=17 for saturation.
module tb_mac_psum_accumulator;

    logic clk;
    logic rst_n;
    logic clear0;
    logic clear1;
    int   checks;
    int   failures;

    mac_psum_accumulator_if #(.SUM_W(16), .ACC_W(24), .N_SLICES(4)) if0 ();
    mac_psum_accumulator_if #(.SUM_W(16), .ACC_W(17), .N_SLICES(4)) if1 ();

    mac_psum_accumulator #(.SUM_W(16), .ACC_W(24), .N_SLICES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear0), .bus(if0.slave)
    );
    mac_psum_accumulator #(.SUM_W(16), .ACC_W(17), .N_SLICES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1), .bus(if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat0(input logic [15:0] s, input logic [15:0] g);
        if0.in_valid  = 1'b1;
        if0.sum_in    = s;
        if0.golden_in = g;
        @(posedge clk); #1;
        if0.in_valid  = 1'b0;
    endtask

    task automatic beat1(input logic [15:0] s, input logic [15:0] g);
        if1.in_valid  = 1'b1;
        if1.sum_in    = s;
        if1.golden_in = g;
        @(posedge clk); #1;
        if1.in_valid  = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; clear0 = 1'b0; clear1 = 1'b0;
        if0.in_valid = 1'b0; if0.sum_in = 16'd0; if0.golden_in = 16'd0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.sum_in = 16'd0; if1.golden_in = 16'd0; if1.out_ready = 1'b0;
        #3;
        chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
        chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_out_data", 32'(if0.out_data), 32'd0);
        chk("rst_result_cnt", 32'(if0.result_cnt), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Equal sums, consumer always ready
        beat0(16'd100, 16'd100);
        beat0(16'd200, 16'd200);
        beat0(16'd300, 16'd300);
        chk("t1_not_yet_valid", 32'(if0.out_valid), 32'd0);
        beat0(16'd400, 16'd400);
        chk("t1_valid", 32'(if0.out_valid), 32'd1);
        chk("t1_in_ready_low", 32'(if0.in_ready), 32'd0);
        chk("t1_data", 32'(if0.out_data), 32'd1000);
        chk("t1_golden", 32'(if0.out_golden), 32'd1000);
        chk("t1_err", 32'(if0.out_err_cnt), 32'd0);
        chk("t1_mismatch", 32'(if0.out_mismatch), 32'd0);
        chk("t1_sat", 32'(if0.out_sat), 32'd0);
        @(posedge clk); #1;
        chk("t1_valid_drop", 32'(if0.out_valid), 32'd0);
        chk("t1_result_cnt", 32'(if0.result_cnt), 32'd1);
        chk("t1_in_ready_back", 32'(if0.in_ready), 32'd1);

        // Mismatching beats, then backpressure
        if0.out_ready = 1'b0;
        beat0(16'd10, 16'd10);
        beat0(16'd20, 16'd25);
        beat0(16'd30, 16'd30);
        beat0(16'd40, 16'd41);
        chk("t2_valid", 32'(if0.out_valid), 32'd1);
        chk("t2_data", 32'(if0.out_data), 32'd100);
        chk("t2_golden", 32'(if0.out_golden), 32'd106);
        chk("t2_err", 32'(if0.out_err_cnt), 32'd2);
        chk("t2_mismatch", 32'(if0.out_mismatch), 32'd1);
        if0.in_valid = 1'b1; if0.sum_in = 16'd999; if0.golden_in = 16'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_hold_in_ready", 32'(if0.in_ready), 32'd0);
            chk("t3_hold_valid", 32'(if0.out_valid), 32'd1);
            chk("t3_hold_data", 32'(if0.out_data), 32'd100);
            chk("t3_hold_golden", 32'(if0.out_golden), 32'd106);
            chk("t3_hold_err", 32'(if0.out_err_cnt), 32'd2);
        end
        if0.in_valid = 1'b0; if0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_release_valid", 32'(if0.out_valid), 32'd0);
        chk("t3_result_cnt", 32'(if0.result_cnt), 32'd2);
        if0.out_ready = 1'b0;
        beat0(16'd1, 16'd1);
        beat0(16'd2, 16'd2);
        beat0(16'd3, 16'd3);
        beat0(16'd4, 16'd4);
        chk("t3_next_data", 32'(if0.out_data), 32'd10);
        chk("t3_next_err", 32'(if0.out_err_cnt), 32'd0);
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_next_result_cnt", 32'(if0.result_cnt), 32'd3);

        // Clear mid-accumulation; beat during clear is dropped
        if0.out_ready = 1'b0;
        beat0(16'd5, 16'd7);
        beat0(16'd6, 16'd6);
        clear0 = 1'b1;
        if0.in_valid = 1'b1; if0.sum_in = 16'd50; if0.golden_in = 16'd51;
        @(posedge clk); #1;
        clear0 = 1'b0; if0.in_valid = 1'b0;
        chk("t5_clear_data", 32'(if0.out_data), 32'd0);
        chk("t5_clear_err", 32'(if0.out_err_cnt), 32'd0);
        chk("t5_clear_valid", 32'(if0.out_valid), 32'd0);
        chk("t5_clear_in_ready", 32'(if0.in_ready), 32'd1);
        beat0(16'd1, 16'd1);
        beat0(16'd2, 16'd2);
        beat0(16'd3, 16'd3);
        beat0(16'd4, 16'd4);
        chk("t5_valid", 32'(if0.out_valid), 32'd1);
        chk("t5_data", 32'(if0.out_data), 32'd10);
        chk("t5_err", 32'(if0.out_err_cnt), 32'd0);
        chk("t5_result_cnt_kept", 32'(if0.result_cnt), 32'd3);
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_result_cnt", 32'(if0.result_cnt), 32'd4);

        // Saturation on the 17-bit accumulator
        beat1(16'd65535, 16'd0);
        beat1(16'd65535, 16'd0);
        beat1(16'd65535, 16'd0);
        beat1(16'd65535, 16'd0);
        chk("t4_valid", 32'(if1.out_valid), 32'd1);
        chk("t4_data", 32'(if1.out_data), 32'd131071);
        chk("t4_golden", 32'(if1.out_golden), 32'd0);
        chk("t4_sat", 32'(if1.out_sat), 32'd1);
        chk("t4_err", 32'(if1.out_err_cnt), 32'd4);
        chk("t4_mismatch", 32'(if1.out_mismatch), 32'd1);
        if1.out_ready = 1'b1;
        @(posedge clk); #1;
        if1.out_ready = 1'b0;
        beat1(16'd1, 16'd1);
        beat1(16'd2, 16'd2);
        beat1(16'd3, 16'd3);
        beat1(16'd4, 16'd4);
        chk("t4_next_sat", 32'(if1.out_sat), 32'd0);
        chk("t4_next_data", 32'(if1.out_data), 32'd10);
        chk("t4_next_mismatch", 32'(if1.out_mismatch), 32'd0);
        chk("t4_result_cnt", 32'(if1.result_cnt), 32'd1);

        // Asynchronous reset while holding a result
        if0.out_ready = 1'b0;
        beat0(16'd100, 16'd100);
        beat0(16'd100, 16'd100);
        beat0(16'd100, 16'd100);
        beat0(16'd100, 16'd100);
        chk("t6_hold_valid", 32'(if0.out_valid), 32'd1);
        chk("t6_hold_data", 32'(if0.out_data), 32'd400);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(if0.out_valid), 32'd0);
        chk("t6_rst_data", 32'(if0.out_data), 32'd0);
        chk("t6_rst_in_ready", 32'(if0.in_ready), 32'd1);
        chk("t6_rst_result_cnt", 32'(if0.result_cnt), 32'd0);
        chk("t6_rst_dut1_valid", 32'(if1.out_valid), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
